cluster_eval_scheduler: RTL
===========================

// Module: cluster_eval_scheduler
// PURPOSE
//  Shares one learned-logic cluster (a set of combinational output-bit modules) among NREQ vector sources.
//  - Round-robin arbitration between the sources.
//  - Drives the cluster input bus from a register, waits EVAL_LAT cycles, then captures the cluster outputs.
//  - Returns each result to its source with a tag, a golden-compare flag and running vector/mismatch counters.
//  - Sits between test-vector streamers and the cluster_N top; supplies the accuracy figures for each cluster.
// PARAMETERS
//  IN_W     1894  width of cluster input vector
//  OUT_W    1     number of output bits the cluster produces
//  NREQ     4     number of requesters (>=2)
//  EVAL_LAT 2     cycles allowed for cluster combinational settle (>=1)
//  CNT_W    32    width of vec_count / err_count
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           synchronous active-low reset
//  req_valid    in   NREQ        requester k has a vector
//  req_ready    out  NREQ        one-hot grant; transfer when valid&ready
//  req_vec      in   NREQ*IN_W   vector k at [k*IN_W +: IN_W]
//  req_exp      in   NREQ*OUT_W  golden output for vector k
//  cl_in        out  IN_W        registered drive to cluster input
//  cl_out       in   OUT_W       cluster result (combinational from cl_in)
//  rsp_valid    out  1           response available
//  rsp_ready    in   1           consumer accepts response
//  rsp_id       out  $clog2(NREQ) requester index of response
//  rsp_bits     out  OUT_W       captured cl_out
//  rsp_mismatch out  1           rsp_bits != golden of that vector
//  vec_count    out  CNT_W       vectors completed (response handshaken)
//  err_count    out  CNT_W       completed vectors with mismatch
//  clr_counts   in   1           synchronous clear of both counters
// BEHAVIOUR
//  Reset: state IDLE; rr pointer 0; req_ready=0; rsp_valid=0; rsp_id=0; rsp_bits=0; rsp_mismatch=0;
//   cl_in=0; both counters 0. Reset mid-transaction discards it; no response is issued.
//  FSM states:
//   IDLE: grant = first k with req_valid[k], searching from rr_ptr upward with wrap.
//     req_ready = onehot(grant) combinationally, and only in IDLE.
//     On transfer: cl_in<=req_vec[k]; exp_r<=req_exp[k]; id_r<=k; rr_ptr<=(k+1)%NREQ; wcnt<=EVAL_LAT-1; ->EVAL.
//     No valid: stay; rr_ptr unchanged.
//   EVAL: wcnt decrements each cycle. When wcnt==0:
//     rsp_bits<=cl_out; rsp_mismatch<=(cl_out!=exp_r); rsp_id<=id_r; rsp_valid<=1; ->RESP.
//   RESP: hold all rsp_* stable while rsp_ready=0.
//     On rsp_valid&rsp_ready: rsp_valid<=0; vec_count+=1; err_count+=rsp_mismatch; ->IDLE.
//  Latency: transfer at edge t -> rsp_valid high after edge t+EVAL_LAT.
//   With rsp_ready tied high, sustained throughput is 1 vector per EVAL_LAT+2 cycles.
//  cl_in changes only on a transfer edge; it holds the last vector while idle.
//  Counters saturate at all-ones; err_count <= vec_count always.
//  clr_counts together with a completing handshake: clear wins, both counters read 0 next cycle.
//  req_valid may drop without transfer (no obligation on source); the grant re-evaluates every cycle.
//  A requester that is not granted sees req_ready=0 and must hold its data; no starvation.
//   Any requester is granted within NREQ transactions.
// STRUCTURE
//  Package cluster_eval_pkg: state enum {IDLE,EVAL,RESP}; localparam ID_W=$clog2(NREQ);
//   function for onehot-to-index conversion.
//  Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs onehot grant and index; purely combinational.
//  Top holds the FSM, wait counter, vector/golden/id registers, response registers and counters.
// TESTING
//  1 Single requester 0, vec=A, cluster model returns 1, exp=1, rsp_ready=1
//    -> rsp_valid at t+2, rsp_id=0, rsp_mismatch=0, vec_count=1, err_count=0.
//  2 All 4 req_valid held high, 8 transactions
//    -> grant order 0,1,2,3,0,1,2,3; each req_ready pulse exactly 1 cycle.
//  3 exp=0 vs cluster output 1
//    -> rsp_mismatch=1, err_count=1; rsp_ready low 5 cycles -> rsp_* stable; no new req_ready pulse.
//  4 clr_counts asserted on the cycle a response handshake completes with vec_count=7 -> both counters 0.
//  5 rst_n low in EVAL
//    -> next cycle rsp_valid=0, cl_in=0, counters 0; no response ever issued for the aborted vector.
//  6 vec_count preloaded by force to 2^CNT_W-1, one more vector -> count stays 2^CNT_W-1.

Source files
------------

// File: rtl/cluster_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_eval_pkg
//  Purpose  : Shared types and helpers for the cluster evaluation scheduler
//  Revision : 1.0  initial release
// ============================================================================
package cluster_eval_pkg;

  // Scheduler phases: waiting for a vector, letting the cluster settle,
  // presenting the result until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index of the set bit of a one-hot vector (0 when no bit is set).
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first requester at or above
//             ptr, wrapping past NREQ-1 back to 0
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import cluster_eval_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            grant_valid
);

  // One extra bit so ptr+offset never overflows before the wrap subtraction.
  localparam int SW = ID_W + 1;

  // Walk the requesters starting at ptr and grant the first active one.
  always_comb begin
    logic [SW-1:0]   sum;
    logic [ID_W-1:0] k;
    logic            found;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      k = sum[ID_W-1:0];
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Encode the winning position and flag whether anything was granted.
  always_comb begin
    idx         = ID_W'(onehot_to_idx(32'(grant)));
    grant_valid = |grant;
  end

endmodule
`default_nettype wire

// File: rtl/cluster_eval_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_eval_scheduler
//  Purpose  : Time-shares one combinational logic cluster among NREQ vector
//             sources, compares each result against its golden value and
//             keeps saturating vector / mismatch counters
//  Revision : 1.0  initial release
// ============================================================================
module cluster_eval_scheduler
  import cluster_eval_pkg::*;
#(
  parameter int IN_W     = 1894,
  parameter int OUT_W    = 1,
  parameter int NREQ     = 4,
  parameter int EVAL_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*IN_W-1:0]      req_vec,
  input  logic [NREQ*OUT_W-1:0]     req_exp,
  output logic [IN_W-1:0]           cl_in,
  input  logic [OUT_W-1:0]          cl_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [OUT_W-1:0]          rsp_bits,
  output logic                      rsp_mismatch,
  output logic [CNT_W-1:0]          vec_count,
  output logic [CNT_W-1:0]          err_count,
  input  logic                      clr_counts
);

  localparam int ID_W = $clog2(NREQ);
  // Wait counter only has to hold EVAL_LAT-1.
  localparam int WC_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
  localparam logic [WC_W-1:0]  WC_INIT = WC_W'(EVAL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_d;
  logic [ID_W-1:0]   rr_ptr, grant_idx, id_r;
  logic [NREQ-1:0]   grant;
  logic              grant_valid;
  logic [WC_W-1:0]   wcnt;
  logic [OUT_W-1:0]  exp_r;
  logic              xfer, capture, done;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .idx         (grant_idx),
    .grant_valid (grant_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, grant exposure and the one-cycle strobes that steer the datapath.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    xfer      = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // Grant is only ever offered to a valid requester, so any grant is a transfer.
        if (rst_n) req_ready = grant;
        if (grant_valid) begin
          xfer    = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (wcnt == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted vector onto the cluster, remember its golden/id, count down the settle time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cl_in  <= '0;
      exp_r  <= '0;
      id_r   <= '0;
      rr_ptr <= '0;
      wcnt   <= '0;
    end else if (xfer) begin
      cl_in  <= req_vec[grant_idx*IN_W +: IN_W];
      exp_r  <= req_exp[grant_idx*OUT_W +: OUT_W];
      id_r   <= grant_idx;
      rr_ptr <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
      wcnt   <= WC_INIT;
    end else if (state == EVAL && wcnt != '0) begin
      wcnt <= wcnt - WC_W'(1);
    end
  end

  // Capture the settled cluster output and hold it until the consumer accepts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_bits     <= '0;
      rsp_mismatch <= 1'b0;
    end else if (capture) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= id_r;
      rsp_bits     <= cl_out;
      rsp_mismatch <= (cl_out != exp_r);
    end else if (done) begin
      rsp_valid    <= 1'b0;
    end
  end

  // Saturating accuracy counters; a clear beats a simultaneous completion.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_counts) begin
      vec_count <= '0;
      err_count <= '0;
    end else if (done) begin
      if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_W'(1);
      if (rsp_mismatch && err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
